// File: rtl/wordle_pkg.sv
// Shared constants, state encoding and byte helper for the Wordle
// guess scoring controller.
package wordle_pkg;

    localparam int WORD_LEN = 5;
    localparam int MAX_ROWS = 6;

    localparam logic [2:0] LAST_IDX = 3'(WORD_LEN - 1);
    localparam logic [2:0] LAST_ROW = 3'(MAX_ROWS - 1);
    localparam logic [2:0] ROW_LIM  = 3'(MAX_ROWS);
    localparam logic [2:0] COL_LIM  = 3'(WORD_LEN);

    localparam logic [1:0] C_EMPTY  = 2'b00;
    localparam logic [1:0] C_GRAY   = 2'b01;
    localparam logic [1:0] C_YELLOW = 2'b10;
    localparam logic [1:0] C_GREEN  = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    // Letter 0 is the most significant byte.
    function automatic logic [7:0] letter(
        input logic [39:0] w,
        input logic [2:0]  i
    );
        logic [7:0] b;
        case (i)
            3'd0:    b = w[39:32];
            3'd1:    b = w[31:24];
            3'd2:    b = w[23:16];
            3'd3:    b = w[15:8];
            3'd4:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wordle_guess_ctrl_if.sv
// Request, result and tile-read signals of the guess controller.
interface wordle_guess_ctrl_if;

    logic        start;
    logic        clear;
    logic [39:0] guess;
    logic [39:0] secret;
    logic [2:0]  rd_row;
    logic [2:0]  rd_col;
    logic [1:0]  rd_color;
    logic [9:0]  colors;
    logic [2:0]  row;
    logic        busy;
    logic        done;
    logic        win;
    logic        lose;

    modport master (
        output start, clear, guess, secret, rd_row, rd_col,
        input  rd_color, colors, row, busy, done, win, lose
    );

    modport slave (
        input  start, clear, guess, secret, rd_row, rd_col,
        output rd_color, colors, row, busy, done, win, lose
    );

endinterface

// File: rtl/wordle_tile_store.sv
// 6x5 board of 2-bit tile colors, written a full row at a time.
import wordle_pkg::*;

module wordle_tile_store (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       we,
    input  logic [2:0] wr_row,
    input  logic [9:0] wr_data,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [1:0] rd_color
);

    logic [9:0] mem [MAX_ROWS];
    logic [9:0] sel;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < MAX_ROWS; r++) mem[r] <= '0;
        end else if (clr) begin
            for (int r = 0; r < MAX_ROWS; r++) mem[r] <= '0;
        end else if (we && wr_row < ROW_LIM) begin
            mem[wr_row] <= wr_data;
        end
    end

    always_comb begin
        sel      = '0;
        rd_color = C_EMPTY;
        if (rd_row < ROW_LIM && rd_col < COL_LIM) begin
            sel = mem[rd_row];
            case (rd_col)
                3'd0:    rd_color = sel[9:8];
                3'd1:    rd_color = sel[7:6];
                3'd2:    rd_color = sel[5:4];
                3'd3:    rd_color = sel[3:2];
                3'd4:    rd_color = sel[1:0];
                default: rd_color = C_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/wordle_guess_ctrl.sv
// Scores a five-letter guess in a green pass then a yellow pass and
// commits the row to the board.
import wordle_pkg::*;

module wordle_guess_ctrl (
    input  logic              Clk,
    input  logic              reset_n,
    wordle_guess_ctrl_if.slave bus
);

    logic [1:0]  state;
    logic [2:0]  idx;
    logic [39:0] guess_q;
    logic [39:0] secret_q;
    logic [4:0]  used;
    logic [4:0]  match;
    logic [1:0]  col [WORD_LEN];
    logic [9:0]  colors_q;
    logic [2:0]  row_q;
    logic        done_q;
    logic        win_q;
    logic        lose_q;

    logic        accept;
    logic        g_eq;
    logic        yfound;
    logic [2:0]  yidx;
    logic [9:0]  row_data;
    logic        all_green;

    assign accept = state == S_IDLE && bus.start && !bus.clear
                    && !win_q && !lose_q;
    assign g_eq      = letter(guess_q, idx) == letter(secret_q, idx);
    assign row_data  = {col[0], col[1], col[2], col[3], col[4]};
    assign all_green = &match;

    // Descending scan leaves the lowest unused matching position.
    always_comb begin
        yfound = 1'b0;
        yidx   = '0;
        for (int j = WORD_LEN - 1; j >= 0; j--) begin
            if (!used[j] &&
                letter(secret_q, 3'(j)) == letter(guess_q, idx)) begin
                yfound = 1'b1;
                yidx   = 3'(j);
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            guess_q  <= '0;
            secret_q <= '0;
            used     <= '0;
            match    <= '0;
            for (int k = 0; k < WORD_LEN; k++) col[k] <= C_EMPTY;
            colors_q <= '0;
            row_q    <= '0;
            done_q   <= 1'b0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                state    <= S_IDLE;
                idx      <= '0;
                used     <= '0;
                match    <= '0;
                colors_q <= '0;
                row_q    <= '0;
                win_q    <= 1'b0;
                lose_q   <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (accept) begin
                            guess_q  <= bus.guess;
                            secret_q <= bus.secret;
                            used     <= '0;
                            match    <= '0;
                            idx      <= '0;
                            state    <= S_GREEN;
                        end
                    end
                    S_GREEN: begin
                        if (g_eq) begin
                            col[idx]   <= C_GREEN;
                            used[idx]  <= 1'b1;
                            match[idx] <= 1'b1;
                        end else begin
                            col[idx] <= C_GRAY;
                        end
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_YELLOW;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    S_YELLOW: begin
                        if (!match[idx] && yfound) begin
                            col[idx]   <= C_YELLOW;
                            used[yidx] <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_COMMIT;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    S_COMMIT: begin
                        colors_q <= row_data;
                        row_q    <= row_q + 3'd1;
                        if (all_green) win_q <= 1'b1;
                        else if (row_q == LAST_ROW) lose_q <= 1'b1;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    wordle_tile_store u_store (
        .Clk      (Clk),
        .reset_n  (reset_n),
        .clr      (bus.clear),
        .we       (state == S_COMMIT),
        .wr_row   (row_q),
        .wr_data  (row_data),
        .rd_row   (bus.rd_row),
        .rd_col   (bus.rd_col),
        .rd_color (bus.rd_color)
    );

    assign bus.colors = colors_q;
    assign bus.row    = row_q;
    assign bus.busy   = state != S_IDLE;
    assign bus.done   = done_q;
    assign bus.win    = win_q;
    assign bus.lose   = lose_q;

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// Scoreboard bench for wordle_guess_ctrl: directed games, clear,
// reset and ignored-start cases.
module tb_wordle_guess_ctrl;

    logic Clk = 1'b0;
    logic reset_n = 1'b0;

    wordle_guess_ctrl_if bus ();

    wordle_guess_ctrl dut (
        .Clk     (Clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [9:0] colors;
        logic [2:0] row;
        logic       win;
        logic       lose;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the scoreboard.
    always @(negedge Clk) begin
        exp_t e;
        exp_t got;
        if (reset_n && bus.done) begin
            got = {bus.colors, bus.row, bus.win, bus.lose};
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(got), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("done_result", 32'(got), 32'(e));
            end
        end
    end

    task automatic pulse_start();
        @(negedge Clk);
        bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge Clk);
        bus.clear = 1'b1;
        @(negedge Clk);
        bus.clear = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk);
            n++;
            #1;
            if (bus.done) break;
        end
        if (!bus.done) chk("done_timeout", 0, 1);
        @(negedge Clk);
    endtask

    task automatic play(input logic [39:0] s, input logic [39:0] g,
                        input exp_t e);
        int n;
        bus.secret = s;
        bus.guess  = g;
        sb.push_back(e);
        pulse_start();
        wait_done(n);
        chk("latency", n, 11);
    endtask

    task automatic rd(input logic [2:0] r, input logic [2:0] c,
                      input logic [1:0] e);
        bus.rd_row = r;
        bus.rd_col = c;
        #1;
        chk($sformatf("rd_%0d_%0d", r, c), bus.rd_color, e);
    endtask

    task automatic board_empty(string name);
        logic [1:0] acc;
        acc = '0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 5; c++) begin
                bus.rd_row = 3'(r);
                bus.rd_col = 3'(c);
                #1;
                acc = acc | bus.rd_color;
            end
        end
        chk(name, acc, 0);
    endtask

    task automatic outs_zero(string name);
        chk(name, {bus.colors, bus.row, bus.busy, bus.done,
                   bus.win, bus.lose}, 0);
    endtask

    initial begin
        int n;
        logic seen;
        bus.start  = 1'b0;
        bus.clear  = 1'b0;
        bus.guess  = '0;
        bus.secret = '0;
        bus.rd_row = '0;
        bus.rd_col = '0;
        repeat (3) @(negedge Clk);
        outs_zero("reset_outs");
        reset_n = 1'b1;

        play("CRANE", "CRANE", '{10'h3FF, 3'd1, 1'b1, 1'b0});
        chk("crane_win", bus.win, 1);
        chk("crane_row", bus.row, 1);
        for (int c = 0; c < 5; c++) rd(3'd0, 3'(c), 2'b11);

        pulse_start();
        repeat (3) @(negedge Clk);
        chk("win_blocks_start", bus.busy, 0);
        chk("win_row_hold", bus.row, 1);

        pulse_clear();
        chk("clear_row", bus.row, 0);
        chk("clear_win", bus.win, 0);
        rd(3'd0, 3'd0, 2'b00);

        play("APPLE", "PAPER", '{10'h2B9, 3'd1, 1'b0, 1'b0});
        rd(3'd0, 3'd0, 2'b10);
        rd(3'd0, 3'd2, 2'b11);
        rd(3'd0, 3'd4, 2'b01);

        play("ROBOT", "OOOOO", '{10'h1DD, 3'd2, 1'b0, 1'b0});
        rd(3'd1, 3'd1, 2'b11);
        rd(3'd1, 3'd0, 2'b01);
        rd(3'd6, 3'd0, 2'b00);
        rd(3'd0, 3'd5, 2'b00);
        rd(3'd7, 3'd7, 2'b00);

        bus.secret = "APPLE";
        bus.guess  = "ZZZZZ";
        sb.push_back('{10'h155, 3'd3, 1'b0, 1'b0});
        pulse_start();
        repeat (6) @(negedge Clk);
        chk("busy_in_yellow", bus.busy, 1);
        bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        wait_done(n);
        repeat (15) @(negedge Clk);
        chk("yellow_start_row", bus.row, 3);
        chk("yellow_start_idle", bus.busy, 0);

        play("APPLE", "XXXXX", '{10'h155, 3'd4, 1'b0, 1'b0});
        play("APPLE", "XXXXX", '{10'h155, 3'd5, 1'b0, 1'b0});
        play("APPLE", "XXXXX", '{10'h155, 3'd6, 1'b0, 1'b1});
        chk("lose_set", bus.lose, 1);
        chk("lose_row", bus.row, 6);

        pulse_start();
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge Clk);
            seen = seen | bus.busy;
        end
        chk("lose_blocks_start", seen, 0);
        chk("lose_row_hold", bus.row, 6);

        pulse_clear();
        chk("clear_lose", bus.lose, 0);
        play("APPLE", "PAPER", '{10'h2B9, 3'd1, 1'b0, 1'b0});
        pulse_start();
        repeat (2) @(negedge Clk);
        bus.clear = 1'b1;
        @(negedge Clk);
        bus.clear = 1'b0;
        repeat (15) @(negedge Clk);
        chk("abort_row", bus.row, 0);
        chk("abort_busy", bus.busy, 0);
        board_empty("abort_board");

        play("APPLE", "PAPER", '{10'h2B9, 3'd1, 1'b0, 1'b0});
        bus.secret = "CRANE";
        bus.guess  = "CRANE";
        pulse_start();
        @(negedge Clk);
        chk("busy_in_green", bus.busy, 1);
        #2 reset_n = 1'b0;
        #1;
        outs_zero("async_reset_outs");
        board_empty("reset_board");
        @(negedge Clk);
        reset_n = 1'b1;
        repeat (15) @(negedge Clk);
        chk("post_reset_row", bus.row, 0);
        chk("post_reset_busy", bus.busy, 0);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wordle_guess_ctrl.md
WORDLE_GUESS_CTRL -- requirements
Module: wordle_guess_ctrl

Interface
REQ-001 Clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  single-cycle request to score the current guess (debounced Start_Ack_SCEN pulse).
REQ-004 clear  in  1  synchronous new-game request.
REQ-005 guess  in  40  five ASCII bytes; letter 0 at [39:32], letter 4 at [7:0].
REQ-006 secret  in  40  target word, same byte order as guess.
REQ-007 rd_row  in  3  tile read row, 0..5.
REQ-008 rd_col  in  3  tile read column, 0..4.
REQ-009 rd_color  out  2  combinational tile color at (rd_row, rd_col).
REQ-010 colors  out  10  last scored row; letter 0 at [9:8].
REQ-011 row  out  3  number of committed guesses, 0..6.
REQ-012 busy  out  1  high while an evaluation is in flight.
REQ-013 done  out  1  one-cycle pulse when a row is committed.
REQ-014 win  out  1  sticky: a guess matched secret.
REQ-015 lose  out  1  sticky: sixth guess committed without a match.

Function
REQ-016 Color codes SHALL be 00 empty, 01 gray, 10 yellow, 11 green.
REQ-017 States SHALL be IDLE, GREEN, YELLOW, COMMIT; busy SHALL be high in GREEN, YELLOW and COMMIT.
REQ-018 In IDLE, start with win=0, lose=0 and clear=0 SHALL latch guess and secret, clear the used/match flags, set index i=0 and enter GREEN.
REQ-019 GREEN SHALL take one cycle per letter i=0..4: if guess[i]==secret[i], set color[i]=11, used[i]=1 and match[i]=1; otherwise set color[i]=01. After i=4 it SHALL enter YELLOW with i=0.
REQ-020 YELLOW SHALL take one cycle per letter i=0..4: if match[i]=0, find the lowest j with used[j]=0 and secret[j]==guess[i]; if found, set color[i]=10 and used[j]=1. After i=4 it SHALL enter COMMIT.
REQ-021 Letter comparison SHALL be an exact 8-bit byte compare with no case folding.
REQ-022 COMMIT SHALL last one cycle. It SHALL write color[0..4] into store row `row`, drive the colors output, increment row, set win if all five letters are green, set lose if row becomes 6 and win is not set, pulse done, and return to IDLE.
REQ-023 Latency: if start is sampled at edge 0, done SHALL be high during the cycle following edge 11.
REQ-024 start while busy, or while win or lose is set, SHALL be ignored.
REQ-025 clear SHALL zero the store, colors, row, win and lose, and return to IDLE from any state without pulsing done; clear SHALL win over a simultaneous start.
REQ-026 win SHALL take precedence over lose on the sixth row.
REQ-027 rd_row>5 or rd_col>4 SHALL return rd_color=00.

Reset
REQ-028 reset_n low SHALL immediately force IDLE and zero busy, done, win, lose, row, colors, i, all flags and all 30 tiles.
REQ-029 An evaluation interrupted by reset SHALL leave no partial row written.

Structure
REQ-030 Package wordle_pkg SHALL hold WORD_LEN=5, MAX_ROWS=6, the color code constants and the state encoding.
REQ-031 Sub-module wordle_tile_store SHALL be a 6x5x2-bit register file with a 10-bit row write port, a clear input and a combinational read port.

Verification
REQ-032 secret "CRANE", guess "CRANE", start -> done after 11 edges, colors=0x3FF, win=1, row=1.
REQ-033 secret "APPLE", guess "PAPER" -> colors=0x2B9 (yellow, yellow, green, yellow, gray), win=0.
REQ-034 secret "ROBOT", guess "OOOOO" -> colors=0x1DD (gray, green, gray, green, gray).
REQ-035 Six non-matching guesses -> lose=1 and row=6 after the sixth done; a seventh start produces no done and leaves busy=0.
REQ-036 clear three cycles after start -> no done, row=0, all rd_color=00; reset_n pulsed low mid-GREEN -> all outputs are 0 immediately.
REQ-037 start pulsed during YELLOW -> ignored, exactly one done is produced, row increments by 1.
